shift_arbiter_seq: RTL and testbench
====================================

// Module: shift_arbiter_seq
// PURPOSE
//  Shares one iterative shift engine (SLL/SRL/SRA) between two requesters, e.g. the
//  ALU shift path and a future multiply/normalise unit. Round-robin arbitration
//  accepts one request at a time and shifts STEP bits per cycle until the shift
//  amount is exhausted. The result is then returned tagged with the requester ID.
//  Replaces a full-width combinational barrel shift wherever area matters more than latency.
// PARAMETERS
//  WIDTH  32  data width in bits
//  SHW    5   shift-amount width; equals clog2(WIDTH)
//  STEP   1   bits shifted per SHIFT cycle; power of 2, 1..WIDTH
// PORTS
//  clk         in   1      clock; all state updates on the rising edge
//  rst         in   1      synchronous, active-high reset
//  req0_valid  in   1      requester 0 has a shift pending
//  req0_ready  out  1      requester 0 is accepted this cycle
//  req0_op     in   2      00 SLL, 01 SRL, 10 SRA, 11 pass-through
//  req0_a      in   WIDTH  operand
//  req0_shamt  in   SHW    shift amount (instr[10:6] for R-type shifts)
//  req1_*      same set for requester 1
//  resp_valid  out  1      result is available
//  resp_ready  in   1      consumer takes the result
//  resp_id     out  1      requester that owns the result
//  resp_res    out  WIDTH  shifted result
//  busy        out  1      state != IDLE
// BEHAVIOUR
//  - FSM states: IDLE, SHIFT, DONE.
//  - Reset: state IDLE; resp_valid/resp_id/resp_res/busy are 0; last_grant is 1, so req0
//    wins the first tie. While rst=1, req*_ready is forced to 0.
//    A reset during SHIFT or DONE discards the in-flight operation with no response.
//  - Arbitration is combinational and happens only in IDLE:
//    - With a single valid, that requester gets ready.
//    - With both valid, the requester that is not last_grant gets ready.
//    - At most one ready is high per cycle; both are 0 outside IDLE.
//  - Acceptance edge (valid&&ready):
//    - Latch op, a, shamt, id; set last_grant := id.
//    - If shamt==0 or op==11: res := a, go to DONE. Otherwise cnt := shamt, go to SHIFT.
//  - SHIFT, each edge:
//    - k = min(STEP, cnt). Shift res by k: SLL zero-fill; SRL zero-fill; SRA fills with res[WIDTH-1].
//    - cnt := cnt - k. If the new cnt==0, go to DONE.
//  - Latency: resp_valid rises ceil(shamt/STEP) edges after the acceptance edge
//    (0 edges for shamt==0 or op 11).
//  - Result equals the combinational reference: SLL a<<shamt; SRL a>>shamt;
//    SRA $signed(a)>>>shamt. shamt is unsigned and at most WIDTH-1, so there is no overshift case.
//  - DONE: resp_valid=1 and resp_res/resp_id are held stable until resp_ready.
//    On valid&&ready, go to IDLE.
//    The next request may only be accepted in the following cycle; there is no same-cycle turnaround.
//  - Requests arriving while not IDLE wait; valid must stay high with stable payload until ready.
//  - The resp_res value after a handshake is don't-care; resp_valid is 0.
// TESTING
//  1. req0 SLL a=0x00000001 shamt=4 (STEP=1) -> 4 edges after accept:
//     resp_valid=1, res=0x00000010, id=0.
//  2. req1 SRA a=0x80000000 shamt=31 -> res=0xFFFFFFFF, id=1, 31-cycle latency.
//     Same operand with SRL -> 0x00000001.
//  3. Both valid every cycle from reset, 4 ops -> grants 0,1,0,1.
//     Each ready pulses exactly once per op and never both high.
//  4. shamt=0 or op=11, a=0xDEADBEEF -> resp_valid the cycle after accept, res=0xDEADBEEF.
//     Hold resp_ready=0 for 5 cycles -> output stable, no new accept.
//  5. rst asserted mid-SHIFT of a shamt=20 op -> next cycle IDLE, resp_valid=0, no response.
//     The following request completes normally with the correct result.
//  6. Random op/a/shamt with STEP in {1,4,32} vs. the combinational model.
//     Latency must equal ceil(shamt/STEP) on every op.

Source files
------------

// File: rtl/shift_arbiter_seq.sv
// -----------------------------------------------------------------------------
// shift_arbiter_seq
//   Iterative SLL/SRL/SRA engine shared by two requesters. In IDLE a round-robin
//   arbiter accepts one request. The engine then shifts the operand by up to STEP
//   bits per cycle until the shift amount is used up. The result is presented
//   with the owning requester ID until the consumer takes it.
//
// Parameters
//   WIDTH  data width in bits
//   SHW    shift-amount width (clog2(WIDTH))
//   STEP   bits shifted per SHIFT cycle (power of 2, 1..WIDTH)
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   reqN_valid/ready          request handshake for requester N (N = 0, 1)
//   reqN_op                   00 SLL, 01 SRL, 10 SRA, 11 pass-through
//   reqN_a, reqN_shamt        operand and unsigned shift amount
//   resp_valid/ready          result handshake
//   resp_id, resp_res         owning requester and shifted result
//   busy                      engine not idle
// -----------------------------------------------------------------------------
module shift_arbiter_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [SHW-1:0]   req0_shamt,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [SHW-1:0]   req1_shamt,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_res,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // One extra bit so that STEP == WIDTH (which may equal 2**SHW) still fits.
    localparam logic [SHW:0] STEP_K = (SHW + 1)'(STEP);

    state_t           state_r, state_s;
    logic [1:0]       op_r, op_s;
    logic [WIDTH-1:0] res_r, res_s;
    logic [SHW-1:0]   cnt_r, cnt_s;
    logic             id_r, id_s;
    logic             last_grant_r, last_grant_s;
    logic             resp_valid_r, busy_r;

    logic             grant0_s, grant1_s;
    logic             accept_s;
    logic [1:0]       sel_op_s;
    logic [WIDTH-1:0] sel_a_s;
    logic [SHW-1:0]   sel_shamt_s;
    logic [SHW:0]     k_s;
    logic [WIDTH-1:0] shifted_s;

    // Round-robin grant, only offered in IDLE and never while reset is held.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (!rst && (state_r == IDLE)) begin
            if (req0_valid && req1_valid) begin
                // The requester that did not win last time goes first.
                grant0_s = last_grant_r;
                grant1_s = !last_grant_r;
            end else begin
                grant0_s = req0_valid;
                grant1_s = req1_valid;
            end
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    assign accept_s    = grant0_s | grant1_s;
    assign sel_op_s    = grant1_s ? req1_op    : req0_op;
    assign sel_a_s     = grant1_s ? req1_a     : req0_a;
    assign sel_shamt_s = grant1_s ? req1_shamt : req0_shamt;

    // Step size for this cycle: min(STEP, remaining count).
    always_comb begin
        k_s = {1'b0, cnt_r};
        if ({1'b0, cnt_r} > STEP_K) begin
            k_s = STEP_K;
        end else begin
            k_s = {1'b0, cnt_r};
        end
    end

    // One partial shift of the working result.
    always_comb begin
        shifted_s = res_r;
        case (op_r)
            2'b00:   shifted_s = res_r << k_s;
            2'b01:   shifted_s = res_r >> k_s;
            2'b10:   shifted_s = $signed(res_r) >>> k_s;
            default: shifted_s = res_r;
        endcase
    end

    // Next-state and datapath update.
    always_comb begin
        state_s      = state_r;
        op_s         = op_r;
        res_s        = res_r;
        cnt_s        = cnt_r;
        id_s         = id_r;
        last_grant_s = last_grant_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    op_s         = sel_op_s;
                    id_s         = grant1_s;
                    last_grant_s = grant1_s;
                    res_s        = sel_a_s;
                    cnt_s        = sel_shamt_s;
                    // Nothing to shift: the operand already is the result.
                    if ((sel_shamt_s == {SHW{1'b0}}) || (sel_op_s == 2'b11)) begin
                        state_s = DONE;
                    end else begin
                        state_s = SHIFT;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                res_s = shifted_s;
                cnt_s = cnt_r - k_s[SHW-1:0];
                if (cnt_s == {SHW{1'b0}}) begin
                    state_s = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers; status outputs are registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            op_r         <= 2'b00;
            res_r        <= {WIDTH{1'b0}};
            cnt_r        <= {SHW{1'b0}};
            id_r         <= 1'b0;
            last_grant_r <= 1'b1;
            resp_valid_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            op_r         <= op_s;
            res_r        <= res_s;
            cnt_r        <= cnt_s;
            id_r         <= id_s;
            last_grant_r <= last_grant_s;
            resp_valid_r <= (state_s == DONE);
            busy_r       <= (state_s != IDLE);
        end
    end

    assign req0_ready = grant0_s;
    assign req1_ready = grant1_s;
    assign resp_valid = resp_valid_r;
    assign resp_id    = id_r;
    assign resp_res   = res_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_shift_arbiter_seq.sv
// -----------------------------------------------------------------------------
// tb_shift_arbiter_seq
//   Directed bench for shift_arbiter_seq. Three copies (STEP = 1, 4, 32) share
//   all inputs. Arbitration, hold and reset checks use the STEP=1 copy. Results
//   and latencies are checked on all three copies against a reference model.
// -----------------------------------------------------------------------------
module tb_shift_arbiter_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, resp_ready;
    logic [1:0]  req0_op, req1_op;
    logic [31:0] req0_a, req1_a;
    logic [4:0]  req0_shamt, req1_shamt;

    logic [2:0]  r0, r1, rv, rid, bsy;
    logic [31:0] rres [3];

    int n_checks = 0;
    int n_errors = 0;
    int rdy0_cnt = 0;
    int rdy1_cnt = 0;
    int both_cnt = 0;

    localparam int STEPS [3] = '{1, 4, 32};

    always #5 clk = ~clk;

    shift_arbiter_seq #(.WIDTH(32), .SHW(5), .STEP(1)) u_s1 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(r0[0]), .req0_op(req0_op), .req0_a(req0_a), .req0_shamt(req0_shamt),
        .req1_valid(req1_valid), .req1_ready(r1[0]), .req1_op(req1_op), .req1_a(req1_a), .req1_shamt(req1_shamt),
        .resp_valid(rv[0]), .resp_ready(resp_ready), .resp_id(rid[0]), .resp_res(rres[0]), .busy(bsy[0]));

    shift_arbiter_seq #(.WIDTH(32), .SHW(5), .STEP(4)) u_s4 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(r0[1]), .req0_op(req0_op), .req0_a(req0_a), .req0_shamt(req0_shamt),
        .req1_valid(req1_valid), .req1_ready(r1[1]), .req1_op(req1_op), .req1_a(req1_a), .req1_shamt(req1_shamt),
        .resp_valid(rv[1]), .resp_ready(resp_ready), .resp_id(rid[1]), .resp_res(rres[1]), .busy(bsy[1]));

    shift_arbiter_seq #(.WIDTH(32), .SHW(5), .STEP(32)) u_s32 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(r0[2]), .req0_op(req0_op), .req0_a(req0_a), .req0_shamt(req0_shamt),
        .req1_valid(req1_valid), .req1_ready(r1[2]), .req1_op(req1_op), .req1_a(req1_a), .req1_shamt(req1_shamt),
        .resp_valid(rv[2]), .resp_ready(resp_ready), .resp_id(rid[2]), .resp_res(rres[2]), .busy(bsy[2]));

    // Count ready pulses of the STEP=1 copy as the clock edge sees them.
    always @(posedge clk) begin
        if (r0[0]) rdy0_cnt <= rdy0_cnt + 1;
        if (r1[0]) rdy1_cnt <= rdy1_cnt + 1;
        if (r0[0] && r1[0]) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [4:0] sh);
        case (op)
            2'b00:   return a << sh;
            2'b01:   return a >> sh;
            2'b10:   return $signed(a) >>> sh;
            default: return a;
        endcase
    endfunction

    function automatic int exp_lat(input logic [1:0] op, input logic [4:0] sh, input int step);
        if (sh == 5'd0 || op == 2'b11) return 0;
        return (int'(sh) + step - 1) / step;
    endfunction

    // Present a request and return one tick after its acceptance edge.
    task automatic accept(input bit port, input logic [1:0] op, input logic [31:0] a, input logic [4:0] sh);
        int t;
        if (port == 1'b0) begin
            req0_op = op; req0_a = a; req0_shamt = sh; req0_valid = 1'b1;
        end else begin
            req1_op = op; req1_a = a; req1_shamt = sh; req1_valid = 1'b1;
        end
        #1;
        t = 0;
        while (((port == 1'b0) ? r0[0] : r1[0]) == 1'b0 && t < 100) begin
            tick();
            t++;
        end
        check("accept_timeout", (t < 100) ? 32'd1 : 32'd0, 32'd1);
        check("single_ready", {31'd0, r0[0] & r1[0]}, 32'd0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    // Full operation: accept, wait on all copies, check, optional hold, handshake.
    task automatic run_op(input bit port, input logic [1:0] op, input logic [31:0] a,
                          input logic [4:0] sh, input int hold);
        int          lat [3];
        int          t;
        logic [31:0] exp;
        exp = model(op, a, sh);
        accept(port, op, a, sh);
        for (int i = 0; i < 3; i++) lat[i] = -1;
        t = 0;
        while (t <= 40) begin
            for (int i = 0; i < 3; i++) if (lat[i] < 0 && rv[i]) lat[i] = t;
            if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0) break;
            tick();
            t++;
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("latency_step%0d", STEPS[i]), lat[i], exp_lat(op, sh, STEPS[i]));
            check($sformatf("result_step%0d", STEPS[i]), rres[i], exp);
            check($sformatf("id_step%0d", STEPS[i]), {31'd0, rid[i]}, {31'd0, port});
        end
        for (int h = 0; h < hold; h++) begin
            // The other requester asks meanwhile; it must not be accepted in DONE.
            if (port == 1'b0) begin
                req1_op = 2'b00; req1_a = 32'd1; req1_shamt = 5'd1; req1_valid = 1'b1;
            end else begin
                req0_op = 2'b00; req0_a = 32'd1; req0_shamt = 5'd1; req0_valid = 1'b1;
            end
            #1;
            check("hold_no_ready", {30'd0, r0[0], r1[0]}, 32'd0);
            tick();
            check("hold_valid", {31'd0, rv[0]}, 32'd1);
            check("hold_res", rres[0], exp);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("after_hs_valid", {29'd0, rv}, 32'd0);
        check("after_hs_busy", {29'd0, bsy}, 32'd0);
    endtask

    initial begin
        int t;
        int r0_base, r1_base;
        bit seen;
        rst = 1'b1; resp_ready = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_op = 2'b00; req0_a = 32'd3;     req0_shamt = 5'd2;
        req1_op = 2'b01; req1_a = 32'h100;   req1_shamt = 5'd3;
        tick();
        tick();
        // Reset state, and ready forced low while reset is held.
        check("rst_resp_valid", {29'd0, rv}, 32'd0);
        check("rst_busy", {29'd0, bsy}, 32'd0);
        check("rst_resp_id", {29'd0, rid}, 32'd0);
        check("rst_resp_res", rres[0], 32'd0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("rst_ready_forced", {26'd0, r0, r1}, 32'd0);
        tick();

        // Both requesters valid every cycle from reset: grants alternate 0,1,0,1.
        r0_base = rdy0_cnt;
        r1_base = rdy1_cnt;
        rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            t = 0;
            while (!(r0[0] || r1[0]) && t < 50) begin tick(); t++; end
            check($sformatf("rr_grant0_op%0d", i), {31'd0, r0[0]}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("rr_grant1_op%0d", i), {31'd0, r1[0]}, (i % 2 == 0) ? 32'd0 : 32'd1);
            tick();
            t = 0;
            while (!rv[0] && t < 50) begin tick(); t++; end
            check($sformatf("rr_id_op%0d", i), {31'd0, rid[0]}, (i % 2 == 0) ? 32'd0 : 32'd1);
            check($sformatf("rr_res_op%0d", i), rres[0], (i % 2 == 0) ? 32'h0000000C : 32'h00000020);
            resp_ready = 1'b1;
            tick();
            resp_ready = 1'b0;
            #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        check("rr_ready0_pulses", rdy0_cnt - r0_base, 32'd2);
        check("rr_ready1_pulses", rdy1_cnt - r1_base, 32'd2);

        // Directed shifts.
        run_op(1'b0, 2'b00, 32'h00000001, 5'd4, 0);
        run_op(1'b1, 2'b10, 32'h80000000, 5'd31, 0);
        run_op(1'b1, 2'b01, 32'h80000000, 5'd31, 0);
        run_op(1'b0, 2'b00, 32'hFFFFFFFF, 5'd31, 0);

        // Zero-length cases, with the consumer stalling for 5 cycles.
        run_op(1'b0, 2'b11, 32'hDEADBEEF, 5'd9, 5);
        run_op(1'b1, 2'b00, 32'hDEADBEEF, 5'd0, 5);

        // Reset in the middle of a 20-bit shift drops the operation.
        accept(1'b0, 2'b00, 32'h12345678, 5'd20);
        for (int i = 0; i < 5; i++) tick();
        check("mid_shift_busy", {31'd0, bsy[0]}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("post_rst_valid", {29'd0, rv}, 32'd0);
        check("post_rst_busy", {29'd0, bsy}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (rv[0]) seen = 1'b1;
        end
        check("post_rst_no_resp", {31'd0, seen}, 32'd0);
        run_op(1'b0, 2'b10, 32'hF0000000, 5'd20, 0);

        // Random operations against the reference model on all three STEP sizes.
        for (int n = 0; n < 24; n++) begin
            run_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
                   5'($urandom_range(0, 31)), 0);
        end

        check("never_both_ready", both_cnt, 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
